// File: rtl/tomasulo_core.sv
// -----------------------------------------------------------------------------
// tomasulo_core
//   Out-of-order integer execution core built on Tomasulo's algorithm with an
//   8-entry reorder buffer. Each cycle it tries to issue the instruction at
//   `pc` from a 16x16 instruction memory into the add or mul reservation
//   stations. It executes out of order on a 1-cycle adder and a 3-cycle
//   non-pipelined multiplier, and retires results in program order into a
//   16 x 16-bit register file.
//
//   Instruction: [15:12] op (1 ADD, 2 SUB, 3 MUL, others NOP), [11:8] rd,
//                [7:4] rs1, [3:0] rs2.
//
// Ports
//   clk1          in   1  clock, all state updates on the rising edge
//   rst           in   1  synchronous active-high reset
//   pc            in   4  instruction-memory index to issue this cycle
//   imem_we       in   1  instruction-memory write enable
//   imem_addr     in   4  instruction-memory write address
//   imem_wdata    in  16  instruction-memory write data
//   stall         out  1  combinational: instruction at pc cannot issue now
//   commit_valid  out  1  registered: one instruction retired on last edge
//   commit_rd     out  4  destination register of the retired instruction
//   commit_value  out 16  value written to that register
// -----------------------------------------------------------------------------
module tomasulo_core (
  input  logic        clk1,
  input  logic        rst,
  input  logic [3:0]  pc,
  input  logic        imem_we,
  input  logic [3:0]  imem_addr,
  input  logic [15:0] imem_wdata,
  output logic        stall,
  output logic        commit_valid,
  output logic [3:0]  commit_rd,
  output logic [15:0] commit_value
);

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;

  typedef struct packed {
    logic        busy;
    logic [15:0] vj;
    logic [15:0] vk;
    logic [2:0]  qj;
    logic [2:0]  qk;
    logic        qj_v;
    logic        qk_v;
    logic [2:0]  dest;
  } rs_t;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [3:0]  rd;
    logic [15:0] value;
  } rob_t;

  typedef struct packed {
    logic [15:0] v;
    logic [2:0]  q;
    logic        q_v;
  } src_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0] imem_q   [16];
  logic [15:0] rf_val_q [16];
  logic [15:0] rf_val_d [16];
  logic [2:0]  rf_tag_q [16];
  logic [2:0]  rf_tag_d [16];
  logic        rf_tv_q  [16];
  logic        rf_tv_d  [16];

  rob_t        rob_q [8];
  rob_t        rob_d [8];
  logic [2:0]  head_q, head_d;
  logic [2:0]  tail_q, tail_d;
  logic [3:0]  count_q, count_d;

  rs_t         add_rs_q  [3];
  rs_t         add_rs_d  [3];
  logic        add_sub_q [3];
  logic        add_sub_d [3];
  rs_t         mul_rs_q  [3];
  rs_t         mul_rs_d  [3];

  logic        alu_valid_q, alu_valid_d;
  logic [2:0]  alu_tag_q, alu_tag_d;
  logic [15:0] alu_val_q, alu_val_d;

  logic        mul_busy_q, mul_busy_d;
  logic [1:0]  mul_cnt_q, mul_cnt_d;
  logic [2:0]  mul_tag_q, mul_tag_d;
  logic [15:0] mul_a_q, mul_a_d;
  logic [15:0] mul_b_q, mul_b_d;

  logic        commit_valid_q, commit_valid_d;
  logic [3:0]  commit_rd_q, commit_rd_d;
  logic [15:0] commit_value_q, commit_value_d;

  // ---------------------------------------------------------------------------
  // Decode and result buses
  // ---------------------------------------------------------------------------
  logic [15:0] instr;
  logic [3:0]  op, rd, rs1, rs2;
  logic        is_add, is_mul, rob_full, do_issue, do_commit;
  logic        alu_bus_v, mul_bus_v;
  logic [15:0] mul_prod;

  assign instr  = imem_q[pc];
  assign op     = instr[15:12];
  assign rd     = instr[11:8];
  assign rs1    = instr[7:4];
  assign rs2    = instr[3:0];
  assign is_add = (op == OP_ADD) || (op == OP_SUB);
  assign is_mul = (op == OP_MUL);

  // The adder result is on its bus for the cycle after dispatch; the
  // multiplier's bus fires in the last of its three execute cycles.
  assign alu_bus_v = alu_valid_q;
  assign mul_bus_v = mul_busy_q && (mul_cnt_q == 2'd0);
  assign mul_prod  = mul_a_q * mul_b_q;

  assign do_commit = rob_q[head_q].busy && rob_q[head_q].ready;

  // ---------------------------------------------------------------------------
  // Reservation-station search: lowest free slot, lowest ready slot
  // ---------------------------------------------------------------------------
  logic       add_free, mul_free, add_rdy, mul_rdy;
  logic [1:0] add_free_idx, mul_free_idx, add_rdy_idx, mul_rdy_idx;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    add_free = 1'b0; add_free_idx = '0;
    mul_free = 1'b0; mul_free_idx = '0;
    add_rdy  = 1'b0; add_rdy_idx  = '0;
    mul_rdy  = 1'b0; mul_rdy_idx  = '0;
    // Scan downwards so the lowest matching index is the last one written.
    for (int i = 2; i >= 0; i--) begin
      if (!add_rs_q[i].busy) begin
        add_free = 1'b1; add_free_idx = 2'(i);
      end
      if (!mul_rs_q[i].busy) begin
        mul_free = 1'b1; mul_free_idx = 2'(i);
      end
      if (add_rs_q[i].busy && !add_rs_q[i].qj_v && !add_rs_q[i].qk_v) begin
        add_rdy = 1'b1; add_rdy_idx = 2'(i);
      end
      if (mul_rs_q[i].busy && !mul_rs_q[i].qj_v && !mul_rs_q[i].qk_v) begin
        mul_rdy = 1'b1; mul_rdy_idx = 2'(i);
      end
    end
    // The multiplier is not pipelined: it only takes work when idle.
    mul_rdy = mul_rdy && !mul_busy_q;
  end

  assign rob_full = (count_q == 4'd8);
  assign stall    = !rst && ((is_add && (!add_free || rob_full)) ||
                             (is_mul && (!mul_free || rob_full)));
  assign do_issue = !rst && (is_add || is_mul) && !stall;

  // ---------------------------------------------------------------------------
  // Source operand resolution at issue: register, completed ROB entry,
  // this cycle's broadcast, or wait on the tag.
  // ---------------------------------------------------------------------------
  function automatic src_t resolve(input logic [3:0] r);
    src_t       s;
    logic [2:0] t;
    t     = rf_tag_q[r];
    s.v   = rf_val_q[r];
    s.q   = t;
    s.q_v = 1'b0;
    if (rf_tv_q[r]) begin
      if (rob_q[t].ready)                      s.v   = rob_q[t].value;
      else if (alu_bus_v && (alu_tag_q == t))  s.v   = alu_val_q;
      else if (mul_bus_v && (mul_tag_q == t))  s.v   = mul_prod;
      else                                     s.q_v = 1'b1;
    end
    return s;
  endfunction

  // Capture any broadcast a waiting station is listening for.
  function automatic rs_t wake(input rs_t e);
    rs_t w;
    w = e;
    if (e.qj_v && alu_bus_v && (e.qj == alu_tag_q)) begin w.vj = alu_val_q; w.qj_v = 1'b0; end
    if (e.qj_v && mul_bus_v && (e.qj == mul_tag_q)) begin w.vj = mul_prod;  w.qj_v = 1'b0; end
    if (e.qk_v && alu_bus_v && (e.qk == alu_tag_q)) begin w.vk = alu_val_q; w.qk_v = 1'b0; end
    if (e.qk_v && mul_bus_v && (e.qk == mul_tag_q)) begin w.vk = mul_prod;  w.qk_v = 1'b0; end
    return w;
  endfunction

  src_t src1, src2;
  rs_t  new_rs;

  assign src1   = resolve(rs1);
  assign src2   = resolve(rs2);
  assign new_rs = '{busy: 1'b1, vj: src1.v, vk: src2.v, qj: src1.q, qk: src2.q,
                    qj_v: src1.q_v, qk_v: src2.q_v, dest: tail_q};

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_val_d       = rf_val_q;
    rf_tag_d       = rf_tag_q;
    rf_tv_d        = rf_tv_q;
    rob_d          = rob_q;
    head_d         = head_q;
    tail_d         = tail_q;
    add_sub_d      = add_sub_q;
    alu_valid_d    = 1'b0;
    alu_tag_d      = alu_tag_q;
    alu_val_d      = alu_val_q;
    mul_busy_d     = mul_busy_q;
    mul_cnt_d      = mul_cnt_q;
    mul_tag_d      = mul_tag_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    commit_valid_d = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;

    // Broadcast: wake stations and mark ROB entries complete.
    for (int i = 0; i < 3; i++) begin
      add_rs_d[i] = wake(add_rs_q[i]);
      mul_rs_d[i] = wake(mul_rs_q[i]);
    end
    if (alu_bus_v) begin
      rob_d[alu_tag_q].ready = 1'b1;
      rob_d[alu_tag_q].value = alu_val_q;
    end
    if (mul_bus_v) begin
      rob_d[mul_tag_q].ready = 1'b1;
      rob_d[mul_tag_q].value = mul_prod;
      mul_busy_d             = 1'b0;
    end else if (mul_busy_q) begin
      mul_cnt_d = mul_cnt_q - 2'd1;
    end

    // Dispatch frees the station on the same edge.
    if (add_rdy) begin
      add_rs_d[add_rdy_idx].busy = 1'b0;
      alu_valid_d = 1'b1;
      alu_tag_d   = add_rs_q[add_rdy_idx].dest;
      alu_val_d   = add_sub_q[add_rdy_idx]
                  ? add_rs_q[add_rdy_idx].vj - add_rs_q[add_rdy_idx].vk
                  : add_rs_q[add_rdy_idx].vj + add_rs_q[add_rdy_idx].vk;
    end
    if (mul_rdy) begin
      mul_rs_d[mul_rdy_idx].busy = 1'b0;
      mul_busy_d = 1'b1;
      mul_cnt_d  = 2'd2;
      mul_tag_d  = mul_rs_q[mul_rdy_idx].dest;
      mul_a_d    = mul_rs_q[mul_rdy_idx].vj;
      mul_b_d    = mul_rs_q[mul_rdy_idx].vk;
    end

    // Commit the head entry.
    if (do_commit) begin
      rf_val_d[rob_q[head_q].rd] = rob_q[head_q].value;
      if (rf_tv_q[rob_q[head_q].rd] && (rf_tag_q[rob_q[head_q].rd] == head_q))
        rf_tv_d[rob_q[head_q].rd] = 1'b0;
      rob_d[head_q].busy  = 1'b0;
      rob_d[head_q].ready = 1'b0;
      head_d         = head_q + 3'd1;
      commit_valid_d = 1'b1;
      commit_rd_d    = rob_q[head_q].rd;
      commit_value_d = rob_q[head_q].value;
    end

    // Issue after commit so a fresh rename of rd overrides the tag clear.
    if (do_issue) begin
      rob_d[tail_q] = '{busy: 1'b1, ready: 1'b0, rd: rd, value: 16'd0};
      tail_d        = tail_q + 3'd1;
      rf_tag_d[rd]  = tail_q;
      rf_tv_d[rd]   = 1'b1;
      if (is_add) begin
        add_rs_d[add_free_idx]  = new_rs;
        add_sub_d[add_free_idx] = (op == OP_SUB);
      end else begin
        mul_rs_d[mul_free_idx] = new_rs;
      end
    end

    count_d = count_q + 4'(do_issue) - 4'(do_commit);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the instruction memory is deliberately left out of reset so a
  // program loaded before or during reset survives it; all machine state
  // below is cleared because in-flight work must be discarded.
  always_ff @(posedge clk1) begin
    if (imem_we) imem_q[imem_addr] <= imem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        rf_val_q[k] <= 16'(k);
        rf_tag_q[k] <= '0;
        rf_tv_q[k]  <= 1'b0;
      end
      for (int i = 0; i < 8; i++) rob_q[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        add_rs_q[i]  <= '0;
        add_sub_q[i] <= 1'b0;
        mul_rs_q[i]  <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      alu_valid_q    <= 1'b0;
      alu_tag_q      <= '0;
      alu_val_q      <= '0;
      mul_busy_q     <= 1'b0;
      mul_cnt_q      <= '0;
      mul_tag_q      <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
    end else begin
      rf_val_q       <= rf_val_d;
      rf_tag_q       <= rf_tag_d;
      rf_tv_q        <= rf_tv_d;
      rob_q          <= rob_d;
      add_rs_q       <= add_rs_d;
      add_sub_q      <= add_sub_d;
      mul_rs_q       <= mul_rs_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      alu_valid_q    <= alu_valid_d;
      alu_tag_q      <= alu_tag_d;
      alu_val_q      <= alu_val_d;
      mul_busy_q     <= mul_busy_d;
      mul_cnt_q      <= mul_cnt_d;
      mul_tag_q      <= mul_tag_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;

endmodule

// File: tb/tb_tomasulo_core.sv
// -----------------------------------------------------------------------------
// tb_tomasulo_core
//   Directed bench for tomasulo_core. Small programs are loaded into the
//   instruction memory, a driver steps pc (holding it while stall is high),
//   and a monitor records every retirement. Expected commit streams and
//   edge latencies are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_tomasulo_core;

  logic        clk1 = 1'b0;
  logic        rst;
  logic [3:0]  pc;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        stall;
  logic        commit_valid;
  logic [3:0]  commit_rd;
  logic [15:0] commit_value;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int q_rd[$];
  int q_val[$];
  int q_edge[$];

  tomasulo_core dut (
    .clk1         (clk1),
    .rst          (rst),
    .pc           (pc),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .stall        (stall),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_value (commit_value)
  );

  always #5 clk1 = ~clk1;

  // cyc holds the number of the most recent rising edge.
  always @(posedge clk1) cyc <= cyc + 1;

  always @(negedge clk1) begin
    if (commit_valid) begin
      q_rd.push_back(int'(commit_rd));
      q_val.push_back(int'(commit_value));
      q_edge.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    imem_addr  = 4'(a);
    imem_wdata = d;
    imem_we    = 1'b1;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic clear_q();
    q_rd.delete();
    q_val.delete();
    q_edge.delete();
  endtask

  task automatic do_reset();
    pc  = 4'd15;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_q();
  endtask

  function automatic int edge_of(input int i);
    if (i < q_edge.size()) return q_edge[i];
    return -1000;
  endfunction

  // Steps pc through 0..n-1, holding it while stall is high. e0 is the
  // edge on which pc 0 issues; stalls counts cycles spent stalled.
  task automatic run_prog(input int n, output int e0, output int stalls);
    int idx;
    int guard;
    idx = 0; guard = 0; e0 = -1; stalls = 0;
    pc = 4'd0;
    while (idx < n && guard < 200) begin
      @(negedge clk1);
      if (stall) stalls++;
      else begin
        if (idx == 0) e0 = cyc + 1;
        idx++;
      end
      tick();
      pc = (idx < n) ? 4'(idx) : 4'd15;
      guard++;
    end
    pc = 4'd15;
    check("prog_issued", idx, n);
  endtask

  // Waits (bounded) for n commits, then a few extra cycles to catch extras.
  task automatic wait_commits(input string tag, input int n);
    int guard;
    guard = 0;
    while (q_val.size() < n && guard < 100) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    check(tag, q_val.size(), n);
  endtask

  task automatic exp_commit(input string tag, input int i, input int rd, input int val);
    int g_rd;
    int g_val;
    g_rd = -1; g_val = -1;
    if (i < q_val.size()) begin
      g_rd  = q_rd[i];
      g_val = q_val[i];
    end
    check({tag, "_rd"}, g_rd, rd);
    check({tag, "_val"}, g_val, val);
  endtask

  initial begin
    int e0;
    int st;

    rst        = 1'b1;
    pc         = 4'd15;
    imem_we    = 1'b0;
    imem_addr  = 4'd0;
    imem_wdata = 16'h0000;

    // Clear the program memory while held in reset; address 15 stays NOP.
    for (int a = 0; a < 16; a++) load(a, 16'h0000);
    tick();
    check("rst_commit_valid", int'(commit_valid), 0);
    check("rst_commit_rd",    int'(commit_rd), 0);
    check("rst_commit_value", int'(commit_value), 0);
    check("rst_stall",        int'(stall), 0);
    rst = 1'b0;
    clear_q();

    // ADD r1,r2,r3 then ADD r9,r1,r0: r1 = 5, read back through r9.
    load(0, 16'h1123);
    load(1, 16'h1910);
    run_prog(2, e0, st);
    wait_commits("add_count", 2);
    exp_commit("add_r1", 0, 1, 5);
    exp_commit("add_r9", 1, 9, 5);
    check("add_latency", edge_of(0) - e0, 3);

    // SUB r1,r1,r2: 1 - 2 wraps.
    do_reset();
    load(0, 16'h2112);
    run_prog(1, e0, st);
    wait_commits("sub_count", 1);
    exp_commit("sub_r1", 0, 1, 16'hFFFF);

    // MUL r5,r2,r3 then dependent ADD r6,r5,r1.
    do_reset();
    load(0, 16'h3523);
    load(1, 16'h1651);
    run_prog(2, e0, st);
    wait_commits("muldep_count", 2);
    exp_commit("muldep_r5", 0, 5, 6);
    exp_commit("muldep_r6", 1, 6, 7);
    check("mul_latency", edge_of(0) - e0, 5);
    check("muldep_order", int'(edge_of(1) > edge_of(0)), 1);

    // MUL r7,r3,r3 then independent ADD r8,r1,r1: ADD finishes first but
    // commits second.
    do_reset();
    load(0, 16'h3733);
    load(1, 16'h1811);
    run_prog(2, e0, st);
    wait_commits("order_count", 2);
    exp_commit("order_r7", 0, 7, 9);
    exp_commit("order_r8", 1, 8, 2);
    check("order_r8_edge", edge_of(1) - e0, 6);

    // A MUL occupies the multiplier, then four back-to-back MULs. The first
    // three fill the mul stations; the fourth stalls until one dispatches
    // when the multiplier frees up (two stall cycles).
    do_reset();
    load(0, 16'h3A45);
    load(1, 16'h3B22);
    load(2, 16'h3C23);
    load(3, 16'h3D34);
    load(4, 16'h3E56);
    run_prog(5, e0, st);
    check("mulrs_stall_cycles", st, 2);
    wait_commits("mulrs_count", 5);
    exp_commit("mulrs_r10", 0, 10, 20);
    exp_commit("mulrs_r11", 1, 11, 4);
    exp_commit("mulrs_r12", 2, 12, 6);
    exp_commit("mulrs_r13", 3, 13, 12);
    exp_commit("mulrs_r14", 4, 14, 30);

    // Dependent MUL chain blocks the head while independent ADDs fill the
    // ROB to 8 (one stall cycle); ten entries also wrap the ROB pointers.
    do_reset();
    load(0, 16'h3B33);
    load(1, 16'h3CB3);
    for (int i = 2; i < 10; i++) load(i, {4'h1, 4'hD, 4'(i), 4'h0});
    run_prog(10, e0, st);
    check("robfull_stall_cycles", st, 1);
    wait_commits("robfull_count", 10);
    exp_commit("robfull_r11", 0, 11, 9);
    exp_commit("robfull_r12", 1, 12, 27);
    for (int i = 2; i < 10; i++) exp_commit($sformatf("robfull_add%0d", i), i, 13, i);
    check("robfull_m0_edge", edge_of(0) - e0, 5);
    check("robfull_m1_edge", edge_of(1) - e0, 9);

    // Reset while a MUL is executing: nothing retires afterwards and the
    // registers read back their reset values.
    do_reset();
    load(0, 16'h3523);
    run_prog(1, e0, st);
    tick();
    tick();
    pc  = 4'd0;
    rst = 1'b1;
    @(negedge clk1);
    check("midrst_stall", int'(stall), 0);
    tick();
    rst = 1'b0;
    pc  = 4'd15;
    check("midrst_commit_valid", int'(commit_valid), 0);
    repeat (10) tick();
    check("midrst_no_commit", q_val.size(), 0);
    load(0, 16'h1950);
    load(1, 16'h1A70);
    run_prog(2, e0, st);
    wait_commits("midrst_count", 2);
    exp_commit("midrst_r5", 0, 9, 5);
    exp_commit("midrst_r7", 1, 10, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
